fifo_read_prefetch: RTL and testbench

- Read-side stage directly downstream of the FIFO controller and its synchronous-read RAM.
- Converts the FIFO's request/grant read interface into a valid/ready stream. It pre-fetches words into a 2-entry output buffer, so the consumer sees data with no RAM read latency.
- Sustains one word per cycle when the FIFO is non-empty and the consumer holds m_ready high.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_read_prefetch.sv | 111 +++++++++++
 tb/tb_fifo_read_prefetch.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO read-side prefetch buffer.
package fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_t;

  localparam int BUF_ENTRIES = 2;
  localparam int LEVEL_W     = 2;

endpackage

// File: rtl/fifo_read_prefetch.sv
// Prefetches FIFO words into a 2-entry skid buffer and presents them as a valid/ready stream.
// Write-to-m_valid latency is 3 cycles; m_ready low stalls the head and stops requests via the credit rule.
module fifo_read_prefetch
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               fifo_empty,
  output logic               fifo_read_request,
  input  logic               fifo_read_enable,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [LEVEL_W-1:0] level,
  output logic               overrun_err
);

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic             inflight_q, inflight_d;
  logic             drop_q, drop_d;
  logic             overrun_q, overrun_d;

  logic             pop;
  logic             push;
  logic [2:0]       credit_sum;

  assign level       = state_q;
  assign m_valid     = (state_q != S_EMPTY);
  assign m_data      = entry0_q;
  assign overrun_err = overrun_q;

  assign pop  = m_valid & m_ready;
  assign push = inflight_q & ~drop_q;

  // Counting the word in flight and the pop of this cycle keeps the buffer from ever overfilling.
  assign credit_sum        = {1'b0, level} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_read_request = ~fifo_empty & ~flush & ~reset
                             & (credit_sum < 3'(BUF_ENTRIES));

  always_comb begin
    state_d    = state_q;
    entry0_d   = entry0_q;
    entry1_d   = entry1_q;
    overrun_d  = overrun_q;
    inflight_d = fifo_read_enable;
    drop_d     = flush & fifo_read_enable;

    case (state_q)
      S_EMPTY: begin
        if (push) begin
          entry0_d = mem_rdata;
          state_d  = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          entry0_d = mem_rdata;
        end else if (push) begin
          entry1_d = mem_rdata;
          state_d  = S_TWO;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          entry0_d = entry1_q;
          if (push) begin
            entry1_d = mem_rdata;
          end else begin
            state_d = S_ONE;
          end
        end else if (push) begin
          // Incoming word is dropped; the buffer keeps its contents.
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // A word arriving during flush is discarded by forcing the buffer empty.
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      entry0_q   <= '0;
      entry1_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Bench: behavioural FIFO controller + sync-read RAM feeding the prefetch stage, scoreboard on the output stream.
module tb_fifo_read_prefetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       fifo_empty;
  logic       fifo_read_request;
  logic       fifo_read_enable;
  logic [7:0] mem_rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] level;
  logic       overrun_err;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       inj_grant;
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr, rd_ptr;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         outstanding = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  fifo_read_prefetch #(.WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .fifo_empty        (fifo_empty),
    .fifo_read_request (fifo_read_request),
    .fifo_read_enable  (fifo_read_enable),
    .mem_rdata         (mem_rdata),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .level             (level),
    .overrun_err       (overrun_err)
  );

  // FIFO controller and RAM model
  assign fifo_empty       = (wr_ptr == rd_ptr);
  assign fifo_read_enable = (fifo_read_request & ~fifo_empty) | inj_grant;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= 8'd0;
      rd_ptr    <= 8'd0;
      mem_rdata <= 8'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 8'd1;
      end
      if (fifo_read_enable) begin
        mem_rdata <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 8'd1;
      end
    end
  end

  // Output monitor: in-order scoreboard, hold-stability and flush discard accounting
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
      prev_hold   = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b data=%02h, need valid=1 data=%02h",
                   m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_data: got unexpected word %02h, need no word", m_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL stream_data: got %02h, need %02h", m_data, e);
          end
        end
        outstanding--;
      end
      if (fifo_read_enable) outstanding++;
      if (flush) begin
        for (int k = 0; k < outstanding; k++) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        outstanding = 0;
      end
      prev_hold = m_valid & ~m_ready & ~flush;
      prev_data = m_data;
    end
  end

  task automatic write_word(input logic [7:0] d);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
  endtask

  task automatic end_writes();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_level2(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (level == 2'd2) break;
    end
    checks++;
    if (level !== 2'd2) begin
      errors++;
      $display("FAIL %s_fill: got level=%0d, need 2", name, level);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0 || level !== 2'd0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words left valid=%b level=%0d, need 0 0 0",
               name, exp_q.size(), m_valid, level);
    end
  endtask

  task automatic check_latency(input string name, input logic [7:0] d);
    write_word(d);
    end_writes();   // returns just after edge t
    @(negedge clk); // cycle t+1
    checks++;
    if (fifo_read_request !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_t1: got req=%b valid=%b, need req=1 valid=0", name, fifo_read_request, m_valid);
    end
    @(negedge clk); // cycle t+2
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_t2: got valid=%b, need 0", name, m_valid);
    end
    @(negedge clk); // cycle t+3
    checks++;
    if (m_valid !== 1'b1 || m_data !== d) begin
      errors++;
      $display("FAIL %s_t3: got valid=%b data=%02h, need valid=1 data=%02h", name, m_valid, m_data, d);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || level !== 2'd0) begin
      errors++;
      $display("FAIL %s_t4: got valid=%b level=%0d, need 0 0", name, m_valid, level);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = 8'h00; inj_grant = 1'b0;
    #2;
    checks++;
    if (m_valid !== 1'b0 || level !== 2'd0 || m_data !== 8'h00 ||
        fifo_read_request !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b level=%0d data=%02h req=%b ovr=%b, need all 0",
               m_valid, level, m_data, fifo_read_request, overrun_err);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_basic();
    check_latency("basic", 8'hA5);
  endtask

  task automatic test_streaming();
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) write_word(8'(i));
    end_writes();
    wait_level2("stream");
    checks++;
    if (fifo_read_request !== 1'b0 || m_data !== 8'h01) begin
      errors++;
      $display("FAIL stream_preload: got req=%b data=%02h, need req=0 data=01", fifo_read_request, m_data);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_bubble: got valid=%b at beat %0d, need 1", m_valid, i);
      end
    end
    wait_drain("stream");
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_overrun: got %b, need 0", overrun_err);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'h20 + 8'(i));
    end_writes();
    repeat (6) @(negedge clk);
    checks++;
    if (level !== 2'd2 || fifo_read_request !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h20) begin
      errors++;
      $display("FAIL bp_saturate: got level=%0d req=%b valid=%b data=%02h, need 2 0 1 20",
               level, fifo_read_request, m_valid, m_data);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_toggle();
    m_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
      if (i < 8) begin
        wr_en   = 1'b1;
        wr_data = 8'h30 + 8'(i);
        exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (level > 2'd2) begin
        errors++;
        $display("FAIL toggle_level: got %0d, need <=2", level);
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("toggle");
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    end_writes();
    wait_level2("flush");
    @(posedge clk); #1 m_ready = 1'b1;   // pops 0x11, grants 0x33
    @(posedge clk); #1 flush = 1'b1;     // pops 0x22 while 0x33 is in flight
    @(negedge clk);
    checks++;
    if (fifo_read_request !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: got %b, need 0", fifo_read_request);
    end
    @(posedge clk); #1;
    flush   = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || level !== 2'd0 || fifo_read_request !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got valid=%b level=%0d req=%b, need 0 0 1",
               m_valid, level, fifo_read_request);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("flush");
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    write_word(8'h60); write_word(8'h61); write_word(8'h62);
    end_writes();
    wait_level2("ovr");
    @(posedge clk); #1 inj_grant = 1'b1;
    @(posedge clk); #1 inj_grant = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early: got %b, need 0", overrun_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (overrun_err !== 1'b1 || level !== 2'd2 || m_data !== 8'h60) begin
      errors++;
      $display("FAIL ovr_sticky: got ovr=%b level=%0d data=%02h, need 1 2 60",
               overrun_err, level, m_data);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #3 reset = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || level !== 2'd0 || fifo_read_request !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b level=%0d req=%b ovr=%b, need all 0",
               m_valid, level, fifo_read_request, overrun_err);
    end
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_ready = 1'b1;
    check_latency("post_reset", 8'h5A);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_toggle();
    test_flush();
    test_overrun();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
